pwm_deadtime_modulator: RTL and testbench
=========================================

PWM_DEADTIME_MODULATOR -- requirements
Module: pwm_deadtime_modulator

Interface
REQ-001 SHALL provide parameter CNT_WIDTH, default 6, period counter width; period = 2^CNT_WIDTH cycles (64).
REQ-002 SHALL provide parameter DEAD, default 2, dead-time length in sysclk cycles (legal range 0..15).
REQ-003 SHALL have sysclk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have Enable  input  1  level request to run; stop takes effect at the end of the period.
REQ-006 SHALL have Duty_In  input  7  requested high-side on-time in cycles, sourced from the triangle-wave duty stage.
REQ-007 SHALL have PWM_Hi  output  1  registered high-side gate drive.
REQ-008 SHALL have PWM_Lo  output  1  registered low-side gate drive, complement of PWM_Hi with dead time.
REQ-009 SHALL have Period_Tick  output  1  registered one-cycle strobe marking the last cycle of each period.
REQ-010 SHALL have Running  output  1  high while state is RUN or DRAIN.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN.
REQ-012 IDLE: cnt held 0; PWM_Hi=PWM_Lo=0; Enable=1 -> RUN next cycle, with shadow loaded from Duty_In on that same edge.
REQ-013 RUN: cnt increments by 1 per cycle and wraps from 63 to 0; Enable=0 -> DRAIN next cycle, with cnt continuing.
REQ-014 DRAIN: cnt continues; Enable=1 -> RUN with no gap and no cnt disturbance; at cnt==63 -> IDLE next cycle (Enable=1 on that same cycle -> RUN instead).
REQ-015 Shadow duty SHALL load only on the IDLE->RUN transition or when cnt==63 in RUN/DRAIN; Duty_In changes mid-period have no effect.
REQ-016 Load SHALL saturate: Duty_In >= 64 loads 64; otherwise loads Duty_In unchanged.
REQ-017 Raw compare: raw = 1 when state is RUN/DRAIN and cnt < shadow; otherwise raw = 0.
REQ-018 Run-length counter SHALL count consecutive cycles raw kept the same value, saturating at DEAD+1, and reset to 1 whenever raw changes.
REQ-019 PWM_Hi(t+1) = raw(t) AND runlen(t) >= DEAD+1; PWM_Lo(t+1) = NOT raw(t) AND runlen(t) >= DEAD+1 AND state(t) != IDLE.
REQ-020 Each output SHALL turn off on the cycle after its raw edge, and SHALL never be high together with the other output.
REQ-021 Shadow=0: PWM_Hi never asserts; shadow=64: PWM_Lo never asserts; both extremes remain continuous across period boundaries.
REQ-022 Period_Tick(t+1) = 1 iff cnt(t)==63 and state(t) in RUN/DRAIN.
REQ-023 Running is registered from the next state and matches the state register.
REQ-024 Latency: cnt value k at cycle t is reflected on the outputs at t+1.

Reset
REQ-025 reset=1 SHALL on the next edge force state=IDLE, cnt=0, shadow=0, runlen=0, and PWM_Hi=PWM_Lo=Period_Tick=Running=0.
REQ-026 reset SHALL take priority over Enable; reset mid-period SHALL abort immediately without drain.
REQ-027 After reset deasserts, operation SHALL resume only through the IDLE->RUN path.

Verification
REQ-028 Duty_In=32, DEAD=2, Enable=1 from IDLE -> per 64-cycle period: PWM_Hi high 30 cycles, low-side 30, both-low gaps of 2 after each edge; Period_Tick every 64 cycles.
REQ-029 Duty_In=0 then Duty_In=100 -> first period PWM_Hi=0 throughout, PWM_Lo high after the 2-cycle dead time; next period PWM_Hi high continuously (saturated to 64).
REQ-030 Duty_In changed from 20 to 40 at cnt=10 -> current period on-time stays 20; new on-time takes effect from the next period.
REQ-031 Enable dropped at cnt=5 -> PWM continues to cnt=63, Period_Tick pulses, then IDLE with both outputs low and Running=0; Enable re-raised at cnt=40 -> no interruption.
REQ-032 reset pulsed at cnt=30 while PWM_Hi=1 -> next cycle all outputs 0 and state IDLE.
REQ-033 Assertion SHALL hold over all tests: PWM_Hi AND PWM_Lo never 1 in the same cycle.

Source files
------------

// File: rtl/pwm_deadtime_modulator_if.sv
// Bus bundle for the dead-time PWM modulator: run request and duty in,
// complementary gate drives plus period/status strobes out.
interface pwm_deadtime_modulator_if #(
    parameter int CNT_WIDTH = 6
);
    logic                 Enable;
    logic [CNT_WIDTH:0]   Duty_In;
    logic                 PWM_Hi;
    logic                 PWM_Lo;
    logic                 Period_Tick;
    logic                 Running;

    // Controller side: drives the request and duty, observes the gate drives.
    modport master (
        output Enable,
        output Duty_In,
        input  PWM_Hi,
        input  PWM_Lo,
        input  Period_Tick,
        input  Running
    );

    // Modulator side.
    modport slave (
        input  Enable,
        input  Duty_In,
        output PWM_Hi,
        output PWM_Lo,
        output Period_Tick,
        output Running
    );
endinterface

// File: rtl/pwm_deadtime_modulator.sv
// Complementary PWM modulator with programmable dead time.
// A free-running period counter is compared against a shadowed duty value
// (reloaded only at period boundaries) to form a raw high/low decision.
// Each gate output only turns on once the raw decision has been stable for
// DEAD+1 cycles, which opens a DEAD-cycle both-off gap after every edge.
// Stopping is graceful: dropping Enable drains to the end of the period.
module pwm_deadtime_modulator #(
    parameter int CNT_WIDTH = 6,
    parameter int DEAD      = 2
) (
    input  logic                           sysclk,
    input  logic                           reset,
    pwm_deadtime_modulator_if.slave        bus
);

    localparam int                    RL_W     = 5;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = '1;
    localparam logic [RL_W-1:0]       RL_MAX   = RL_W'(DEAD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_reg,    state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg,      cnt_next;
    logic [CNT_WIDTH:0]     shadow_reg,   shadow_next;
    logic [RL_W-1:0]        runlen_reg,   runlen_next;
    logic                   raw_prev_reg, raw_prev_next;
    logic                   pwm_hi_reg,   pwm_hi_next;
    logic                   pwm_lo_reg,   pwm_lo_next;
    logic                   tick_reg,     tick_next;
    logic                   running_reg,  running_next;

    logic                   active;
    logic                   at_last;
    logic                   raw;
    logic [RL_W-1:0]        runlen_cur;
    logic                   dead_ok;
    logic [CNT_WIDTH:0]     duty_load;
    logic [1:0]             side_raw;
    logic [1:0]             gate_next;

    // Saturated duty: any request with the MSB set means "on for the whole
    // period", so the low bits are cleared to give exactly 2^CNT_WIDTH.
    generate
        for (genvar gi = 0; gi < CNT_WIDTH; gi++) begin : g_duty_sat
            assign duty_load[gi] = bus.Duty_In[CNT_WIDTH] ? 1'b0 : bus.Duty_In[gi];
        end
    endgenerate
    assign duty_load[CNT_WIDTH] = bus.Duty_In[CNT_WIDTH];

    // Raw compare and run-length of the current raw level.
    always_comb begin
        active  = (state_reg != IDLE);
        at_last = (cnt_reg == CNT_LAST);
        raw     = active && ({1'b0, cnt_reg} < shadow_reg);
        if (raw != raw_prev_reg) begin
            runlen_cur = RL_W'(1);
        end else if (runlen_reg >= RL_MAX) begin
            runlen_cur = RL_MAX;
        end else begin
            runlen_cur = runlen_reg + RL_W'(1);
        end
        dead_ok = (runlen_cur >= RL_MAX);
    end

    // Side 0 is the high-side gate, side 1 the low-side gate; each one is
    // released only after its raw request has held for the dead time. The
    // low side is additionally gated by activity so IDLE keeps both off.
    assign side_raw[0] = raw;
    assign side_raw[1] = ~raw & active;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gate
            assign gate_next[gi] = side_raw[gi] & dead_ok;
        end
    endgenerate

    // Next-state, counter, shadow and output decode.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shadow_next   = shadow_reg;
        runlen_next   = runlen_reg;
        raw_prev_next = raw_prev_reg;

        case (state_reg)
            IDLE: begin
                cnt_next      = '0;
                // Run-length restarts from zero so the first period of a
                // fresh start always begins with a full dead-time gap.
                runlen_next   = '0;
                raw_prev_next = 1'b0;
                if (bus.Enable) begin
                    state_next  = RUN;
                    shadow_next = duty_load;
                end
            end
            RUN: begin
                cnt_next      = cnt_reg + CNT_WIDTH'(1);
                runlen_next   = runlen_cur;
                raw_prev_next = raw;
                if (at_last) begin
                    shadow_next = duty_load;
                end
                if (!bus.Enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                cnt_next      = cnt_reg + CNT_WIDTH'(1);
                runlen_next   = runlen_cur;
                raw_prev_next = raw;
                if (at_last) begin
                    shadow_next = duty_load;
                end
                if (bus.Enable) begin
                    state_next = RUN;
                end else if (at_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        pwm_hi_next  = gate_next[0];
        pwm_lo_next  = gate_next[1];
        tick_next    = active && at_last;
        running_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any period immediately.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shadow_reg   <= '0;
            runlen_reg   <= '0;
            raw_prev_reg <= 1'b0;
            pwm_hi_reg   <= 1'b0;
            pwm_lo_reg   <= 1'b0;
            tick_reg     <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shadow_reg   <= shadow_next;
            runlen_reg   <= runlen_next;
            raw_prev_reg <= raw_prev_next;
            pwm_hi_reg   <= pwm_hi_next;
            pwm_lo_reg   <= pwm_lo_next;
            tick_reg     <= tick_next;
            running_reg  <= running_next;
        end
    end

    assign bus.PWM_Hi      = pwm_hi_reg;
    assign bus.PWM_Lo      = pwm_lo_reg;
    assign bus.Period_Tick = tick_reg;
    assign bus.Running     = running_reg;

endmodule

// File: tb/tb_pwm_deadtime_modulator.sv
// Directed bench for the dead-time PWM modulator. Outputs are logged per
// cycle (cycle 1 = first edge after Enable is raised) and checked against
// hand-computed positions and counts.
module tb_pwm_deadtime_modulator;

    logic sysclk;
    logic reset;

    pwm_deadtime_modulator_if #(.CNT_WIDTH(6)) bus ();

    pwm_deadtime_modulator #(
        .CNT_WIDTH (6),
        .DEAD      (2)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int   n_cmp;
    int   n_err;
    int   cyc;
    int   overlap;
    logic hi_log  [0:255];
    logic lo_log  [0:255];
    logic tk_log  [0:255];
    logic run_log [0:255];

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Both gate drives must never be on together.
    always @(negedge sysclk) begin
        if (!reset) begin
            assert (!(bus.PWM_Hi && bus.PWM_Lo))
                else $error("FAIL overlap: PWM_Hi=%0b PWM_Lo=%0b both high", bus.PWM_Hi, bus.PWM_Lo);
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cyc++;
            hi_log[cyc]  = bus.PWM_Hi;
            lo_log[cyc]  = bus.PWM_Lo;
            tk_log[cyc]  = bus.Period_Tick;
            run_log[cyc] = bus.Running;
            if (bus.PWM_Hi && bus.PWM_Lo) overlap++;
        end
    endtask

    // sel: 0 = PWM_Hi, 1 = PWM_Lo, 2 = Period_Tick, 3 = Running
    function automatic int ones(input int sel, input int a, input int b);
        int s;
        s = 0;
        for (int c = a; c <= b; c++) begin
            case (sel)
                0: s += int'(hi_log[c]);
                1: s += int'(lo_log[c]);
                2: s += int'(tk_log[c]);
                default: s += int'(run_log[c]);
            endcase
        end
        return s;
    endfunction

    // Reset, check the cleared outputs, settle one IDLE cycle, then request run.
    task automatic start(input string name, input int duty);
        reset       = 1'b1;
        bus.Enable  = 1'b1;
        bus.Duty_In = 7'd0;
        step();
        check_val({name, "_rst_hi"},   int'(bus.PWM_Hi),      0);
        check_val({name, "_rst_lo"},   int'(bus.PWM_Lo),      0);
        check_val({name, "_rst_tick"}, int'(bus.Period_Tick), 0);
        check_val({name, "_rst_run"},  int'(bus.Running),     0);
        reset      = 1'b0;
        bus.Enable = 1'b0;
        step();
        check_val({name, "_idle_run"}, int'(bus.Running), 0);
        bus.Duty_In = 7'(duty);
        bus.Enable  = 1'b1;
        cyc = 0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        overlap = 0;
        cyc     = 0;
        reset   = 1'b1;
        bus.Enable  = 1'b0;
        bus.Duty_In = 7'd0;

        // 50% duty, dead time 2: 30 high / 30 low per period.
        start("A", 32);
        run(130);
        check_val("A_run1",     int'(run_log[1]), 1);
        check_val("A_hi1",      int'(hi_log[1]),  0);
        check_val("A_hi3",      int'(hi_log[3]),  0);
        check_val("A_hi4",      int'(hi_log[4]),  1);
        check_val("A_hi33",     int'(hi_log[33]), 1);
        check_val("A_hi34",     int'(hi_log[34]), 0);
        check_val("A_lo35",     int'(lo_log[35]), 0);
        check_val("A_lo36",     int'(lo_log[36]), 1);
        check_val("A_lo65",     int'(lo_log[65]), 1);
        check_val("A_lo66",     int'(lo_log[66]), 0);
        check_val("A_hi67",     int'(hi_log[67]), 0);
        check_val("A_hi68",     int'(hi_log[68]), 1);
        check_val("A_hi_count", ones(0, 2, 65),   30);
        check_val("A_lo_count", ones(1, 2, 65),   30);
        check_val("A_tick64",   int'(tk_log[64]), 0);
        check_val("A_tick65",   int'(tk_log[65]), 1);
        check_val("A_tick129",  int'(tk_log[129]), 1);
        check_val("A_ticks",    ones(2, 2, 129),  2);

        // Duty 0 then saturated 100 (loads 64) at the period boundary.
        start("B", 0);
        run(1);
        bus.Duty_In = 7'd100;
        run(140);
        check_val("B_hi_p1",    ones(0, 2, 65),   0);
        check_val("B_lo3",      int'(lo_log[3]),  0);
        check_val("B_lo4",      int'(lo_log[4]),  1);
        check_val("B_lo65",     int'(lo_log[65]), 1);
        check_val("B_hi67",     int'(hi_log[67]), 0);
        check_val("B_hi_p2",    ones(0, 68, 141), 74);
        check_val("B_lo_p2",    ones(1, 66, 141), 0);

        // Duty changed 20 -> 40 at cnt=10: takes effect next period only.
        start("C", 20);
        run(11);
        bus.Duty_In = 7'd40;
        run(130);
        check_val("C_hi_p1",    ones(0, 2, 65),    18);
        check_val("C_hi21",     int'(hi_log[21]),  1);
        check_val("C_hi22",     int'(hi_log[22]),  0);
        check_val("C_hi_p2",    ones(0, 66, 129),  38);
        check_val("C_hi105",    int'(hi_log[105]), 1);
        check_val("C_hi106",    int'(hi_log[106]), 0);

        // Enable dropped at cnt=5: drain to end of period, then IDLE.
        start("D", 32);
        run(6);
        bus.Enable = 1'b0;
        run(64);
        check_val("D_run7",     int'(run_log[7]),  1);
        check_val("D_run64",    int'(run_log[64]), 1);
        check_val("D_run65",    int'(run_log[65]), 0);
        check_val("D_tick65",   int'(tk_log[65]),  1);
        check_val("D_lo65",     int'(lo_log[65]),  1);
        check_val("D_hi_count", ones(0, 2, 65),    30);
        check_val("D_hi66",     int'(hi_log[66]),  0);
        check_val("D_lo_idle",  ones(1, 66, 70),   0);
        check_val("D_run70",    int'(run_log[70]), 0);

        // Enable dropped at cnt=5 and re-raised at cnt=40: no interruption.
        start("E", 32);
        run(6);
        bus.Enable = 1'b0;
        run(35);
        bus.Enable = 1'b1;
        run(100);
        check_val("E_running",  ones(3, 1, 141),   141);
        check_val("E_hi_p2",    ones(0, 66, 129),  30);
        check_val("E_lo_p2",    ones(1, 66, 129),  30);
        check_val("E_ticks",    ones(2, 2, 141),   2);
        check_val("E_tick129",  int'(tk_log[129]), 1);

        // Reset at cnt=30 while PWM_Hi is high, Enable held high.
        start("F", 40);
        run(31);
        check_val("F_hi31",     int'(hi_log[31]), 1);
        reset = 1'b1;
        run(1);
        check_val("F_hi32",     int'(hi_log[32]),  0);
        check_val("F_lo32",     int'(lo_log[32]),  0);
        check_val("F_tick32",   int'(tk_log[32]),  0);
        check_val("F_run32",    int'(run_log[32]), 0);
        reset = 1'b0;
        run(4);
        check_val("F_run33",    int'(run_log[33]), 1);
        check_val("F_hi33",     int'(hi_log[33]),  0);
        check_val("F_hi35",     int'(hi_log[35]),  0);
        check_val("F_hi36",     int'(hi_log[36]),  1);

        check_val("no_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
